// File: rtl/seg7_pkg.sv
// Shared constants and types for the 7-segment display path.
// Segment codes are active-low, ordered gfedcba.
package seg7_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [3:0] AN_OFF    = 4'hF;

    typedef logic [1:0] digit_idx_t;

    localparam logic [6:0] HEX_SEG [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30,
        7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03,
        7'h46, 7'h21, 7'h06, 7'h0E
    };

endpackage

// File: rtl/seg7_scan_mux_hex_to_seg7.sv
// Combinational hex nibble to active-low 7-segment decoder.
// Also used by the single-digit counter blocks.
module hex_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    always_comb begin
        seg = HEX_SEG[nibble];
    end

endmodule

// File: rtl/seg7_scan_mux.sv
// Four-digit time-multiplexed 7-segment driver with frame-coherent shadow
// registers, per-slot anode guard time and optional leading-zero blanking.
module seg7_scan_mux
    import seg7_pkg::*;
#(
    parameter int SCAN_DIV = 50000,
    parameter int GUARD    = 16,
    parameter bit BLANK_LZ = 1'b1
) (
    input  logic        clk,
    input  logic        clear_n,
    input  logic [15:0] value,
    input  logic [3:0]  dp_in,
    input  logic [3:0]  digit_en,
    output logic [3:0]  AN,
    output logic [7:0]  CA,
    output logic        frame_tick
);

    localparam int PW = $clog2(SCAN_DIV);

    logic [PW-1:0] presc_q, presc_d;
    digit_idx_t    idx_q, idx_d;
    logic [15:0]   shadow_val_q, shadow_val_d;
    logic [3:0]    shadow_dp_q, shadow_dp_d;
    logic [3:0]    shadow_en_q, shadow_en_d;
    logic          primed_q, primed_d;
    logic [3:0]    an_q, an_d;
    logic [7:0]    ca_q, ca_d;
    logic          frame_tick_q, frame_tick_d;

    logic          scan_tick;
    logic          load_evt;
    digit_idx_t    top;
    logic          blank;
    logic [3:0]    cur_nibble;
    logic [6:0]    dec_seg;

    hex_to_seg7 u_dec (
        .nibble (cur_nibble),
        .seg    (dec_seg)
    );

    always_comb begin
        scan_tick = (presc_q == PW'(SCAN_DIV - 1));
        load_evt  = !primed_q || (scan_tick && (idx_q == 2'd3));

        presc_d      = scan_tick ? '0 : presc_q + 1'b1;
        idx_d        = scan_tick ? idx_q + 2'd1 : idx_q;
        shadow_val_d = load_evt ? value    : shadow_val_q;
        shadow_dp_d  = load_evt ? dp_in    : shadow_dp_q;
        shadow_en_d  = load_evt ? digit_en : shadow_en_q;
        primed_d     = 1'b1;
        frame_tick_d = load_evt;
    end

    // Highest nonzero nibble decides which leading digits go dark; digit 0 always shows.
    always_comb begin
        top = 2'd0;
        for (int k = 1; k < 4; k++) begin
            if (shadow_val_q[4*k +: 4] != 4'h0) begin
                top = digit_idx_t'(k);
            end
        end
        blank      = BLANK_LZ && (idx_q > top);
        cur_nibble = shadow_val_q[{idx_q, 2'b00} +: 4];
    end

    always_comb begin
        if ((presc_q >= PW'(GUARD)) && shadow_en_q[idx_q]) begin
            an_d = ~(4'b0001 << idx_q);
        end else begin
            an_d = AN_OFF;
        end
        ca_d = {~shadow_dp_q[idx_q], (blank ? SEG_BLANK : dec_seg)};
    end

    always_ff @(posedge clk) begin
        if (!clear_n) begin
            presc_q      <= '0;
            idx_q        <= 2'd0;
            shadow_val_q <= 16'h0000;
            shadow_dp_q  <= 4'h0;
            shadow_en_q  <= 4'h0;
            primed_q     <= 1'b0;
            an_q         <= AN_OFF;
            ca_q         <= 8'hFF;
            frame_tick_q <= 1'b0;
        end else begin
            presc_q      <= presc_d;
            idx_q        <= idx_d;
            shadow_val_q <= shadow_val_d;
            shadow_dp_q  <= shadow_dp_d;
            shadow_en_q  <= shadow_en_d;
            primed_q     <= primed_d;
            an_q         <= an_d;
            ca_q         <= ca_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign AN         = an_q;
    assign CA         = ca_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seg7_scan_mux.sv
// Self-checking bench for seg7_scan_mux: two instances (blanking on/off) share
// stimulus; a time-since-release model feeds expected outputs through a queue.
module tb_seg7_scan_mux;

    localparam int SCAN_DIV = 8;
    localparam int GUARD    = 2;
    localparam int FRAME    = 4 * SCAN_DIV;

    logic        clk = 1'b0;
    logic        clear_n;
    logic [15:0] value;
    logic [3:0]  dp_in;
    logic [3:0]  digit_en;
    logic [3:0]  an_lz, an_nb;
    logic [7:0]  ca_lz, ca_nb;
    logic        ft_lz, ft_nb;

    typedef struct packed {
        logic [3:0] an;
        logic [7:0] ca_lz;
        logic [7:0] ca_nb;
        logic       ft;
    } exp_t;

    exp_t sb_q[$];
    int   vec_cnt  = 0;
    int   miss_cnt = 0;

    logic [6:0] seg_tab [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    int          s_cnt;
    logic [15:0] m_val;
    logic [3:0]  m_dp;
    logic [3:0]  m_en;

    always #5 clk = ~clk;

    seg7_scan_mux #(.SCAN_DIV(SCAN_DIV), .GUARD(GUARD), .BLANK_LZ(1'b1)) dut_lz (
        .clk(clk), .clear_n(clear_n), .value(value), .dp_in(dp_in), .digit_en(digit_en),
        .AN(an_lz), .CA(ca_lz), .frame_tick(ft_lz)
    );

    seg7_scan_mux #(.SCAN_DIV(SCAN_DIV), .GUARD(GUARD), .BLANK_LZ(1'b0)) dut_nb (
        .clk(clk), .clear_n(clear_n), .value(value), .dp_in(dp_in), .digit_en(digit_en),
        .AN(an_nb), .CA(ca_nb), .frame_tick(ft_nb)
    );

    function automatic logic [7:0] modelCa(input logic [15:0] v, input logic [3:0] dp,
                                           input int d, input bit lz);
        int  hi;
        logic [3:0] nib;
        hi = 0;
        for (int k = 0; k < 4; k++) begin
            nib = v[4*k +: 4];
            if (nib != 4'h0) hi = k;
        end
        nib = v[4*d +: 4];
        if (lz && d > hi) return {~dp[d], 7'h7F};
        return {~dp[d], seg_tab[nib]};
    endfunction

    task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vec_cnt++;
        assert (obs === exp)
        else begin
            miss_cnt++;
            $error("[TB] FAIL %s observed=%h expected=%h (cycle %0d)", tag, obs, exp, s_cnt);
        end
    endtask

    // Expected outputs after the next edge depend only on the pre-edge state, which the
    // model tracks as edges elapsed since the last release of clear_n.
    task automatic applyStimulus(input int n);
        exp_t e;
        exp_t got;
        int   slot_pos;
        int   d;
        bit   load;
        repeat (n) begin
            if (!clear_n) begin
                e = '{an: 4'hF, ca_lz: 8'hFF, ca_nb: 8'hFF, ft: 1'b0};
                s_cnt = 0;
                m_val = 16'h0;
                m_dp  = 4'h0;
                m_en  = 4'h0;
            end else begin
                slot_pos = s_cnt % SCAN_DIV;
                d        = (s_cnt / SCAN_DIV) % 4;
                load     = (s_cnt == 0) || (s_cnt % FRAME == FRAME - 1);
                e.an     = (slot_pos >= GUARD && m_en[d]) ? ~(4'b0001 << d) : 4'hF;
                e.ca_lz  = modelCa(m_val, m_dp, d, 1'b1);
                e.ca_nb  = modelCa(m_val, m_dp, d, 1'b0);
                e.ft     = load;
                if (load) begin
                    m_val = value;
                    m_dp  = dp_in;
                    m_en  = digit_en;
                end
                s_cnt++;
            end
            sb_q.push_back(e);
            @(posedge clk);
            #1;
            got = sb_q.pop_front();
            checkOutput("an_lz", {4'h0, an_lz}, {4'h0, got.an});
            checkOutput("an_nb", {4'h0, an_nb}, {4'h0, got.an});
            checkOutput("ca_lz", ca_lz, got.ca_lz);
            checkOutput("ca_nb", ca_nb, got.ca_nb);
            checkOutput("ft_lz", {7'h0, ft_lz}, {7'h0, got.ft});
            checkOutput("ft_nb", {7'h0, ft_nb}, {7'h0, got.ft});
            checkOutput("an_onehot", {7'h0, ($countones(~an_lz) <= 1)}, 8'h01);
        end
    endtask

    task automatic runToSlot(input int d, input int pos);
        for (int i = 0; i < FRAME + 1; i++) begin
            if (((s_cnt / SCAN_DIV) % 4) == d && (s_cnt % SCAN_DIV) == pos) break;
            applyStimulus(1);
        end
    endtask

    initial begin
        s_cnt    = 0;
        m_val    = 16'h0;
        m_dp     = 4'h0;
        m_en     = 4'h0;
        clear_n  = 1'b0;
        value    = 16'h1234;
        dp_in    = 4'h0;
        digit_en = 4'hF;
        applyStimulus(3);

        $display("[TB] release reset, value 1234");
        clear_n = 1'b1;
        applyStimulus(2 * FRAME + 4);

        $display("[TB] leading-zero case 00A0");
        value = 16'h00A0;
        applyStimulus(2 * FRAME);

        $display("[TB] mid-frame value change");
        runToSlot(1, 3);
        value = 16'hBEEF;
        applyStimulus(SCAN_DIV);
        value = 16'h5678;
        applyStimulus(2 * FRAME);

        $display("[TB] sparse enables and decimal point");
        digit_en = 4'b0101;
        dp_in    = 4'b0010;
        value    = 16'h0307;
        applyStimulus(2 * FRAME + 5);

        $display("[TB] one-cycle reset mid-slot");
        digit_en = 4'hF;
        dp_in    = 4'h0;
        value    = 16'h9C1E;
        runToSlot(2, 4);
        clear_n = 1'b0;
        applyStimulus(1);
        clear_n = 1'b1;
        applyStimulus(FRAME + 6);

        $display("[TB] all-zero value");
        value = 16'h0000;
        applyStimulus(2 * FRAME);

        $display("[TB] digit 3 only nonzero, guard boundaries");
        value = 16'hF000;
        dp_in = 4'b1001;
        applyStimulus(2 * FRAME);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
